// File: rtl/bcd_display_pkg.sv
// Shared types and constants for the BCD seven-segment display driver.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package bcd_display_pkg;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_REQ  = 2'd1,
        C_BUSY = 2'd2
    } cap_state_e;

    localparam logic [6:0]  SEG_OFF    = 7'h7F;
    localparam logic [6:0]  SEG_DASH   = 7'h3F;
    localparam int unsigned NUM_DIGITS = 8;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low seven-segment pattern.
// Codes 10-15 are not decimal digits and show a dash.
module bcd_to_7seg
    import bcd_display_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (code_i)
            4'd0: seg_o = 7'h40;
            4'd1: seg_o = 7'h79;
            4'd2: seg_o = 7'h24;
            4'd3: seg_o = 7'h30;
            4'd4: seg_o = 7'h19;
            4'd5: seg_o = 7'h12;
            4'd6: seg_o = 7'h02;
            4'd7: seg_o = 7'h78;
            4'd8: seg_o = 7'h00;
            4'd9: seg_o = 7'h10;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_driver.sv
// Captures converter results on a periodic request and multiplexes them
// onto an 8-digit common-anode display with leading-zero blanking.
module bcd_display_driver
    import bcd_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned UPDATE_DIV  = 10000000,
    parameter bit          LZ_BLANK    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        conv_idle,
    input  logic [31:0] conv_bcd,
    input  logic [7:0]  dots,
    input  logic        blank,
    output logic        conv_trigger,
    output logic [7:0]  anodes,
    output logic [6:0]  segments,
    output logic        dp
);

    localparam int unsigned UW = $clog2(UPDATE_DIV);
    localparam int unsigned RW = $clog2(REFRESH_DIV);

    logic [UW-1:0] upd_cnt_q;
    logic [RW-1:0] ref_cnt_q;
    logic [2:0]    digit_q;
    logic          update_tick;
    logic          ref_wrap;

    cap_state_e    state_q;
    logic          trig_q;
    logic [31:0]   disp_q;

    logic [7:0]    anodes_q, anodes_d;
    logic [6:0]    segments_q, segments_d;
    logic          dp_q, dp_d;

    logic [3:0]    code;
    logic [6:0]    seg_dec;
    logic [7:0]    zero_above;
    logic          suppress;
    logic          off;

    assign update_tick = (upd_cnt_q == UW'(UPDATE_DIV - 1));
    assign ref_wrap    = (ref_cnt_q == RW'(REFRESH_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upd_cnt_q <= '0;
            ref_cnt_q <= '0;
            digit_q   <= '0;
        end else begin
            upd_cnt_q <= update_tick ? '0 : upd_cnt_q + UW'(1);
            ref_cnt_q <= ref_wrap ? '0 : ref_cnt_q + RW'(1);
            if (ref_wrap) begin
                digit_q <= digit_q + 3'd1;
            end
        end
    end

    // Trigger is registered and high only while in C_REQ.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= C_IDLE;
            trig_q  <= 1'b0;
            disp_q  <= '0;
        end else begin
            case (state_q)
                C_IDLE: begin
                    if (update_tick && conv_idle) begin
                        state_q <= C_REQ;
                        trig_q  <= 1'b1;
                    end
                end
                C_REQ: begin
                    if (!conv_idle) begin
                        state_q <= C_BUSY;
                        trig_q  <= 1'b0;
                    end
                end
                C_BUSY: begin
                    if (conv_idle) begin
                        disp_q  <= conv_bcd;
                        state_q <= C_IDLE;
                    end
                end
                default: begin
                    state_q <= C_IDLE;
                    trig_q  <= 1'b0;
                end
            endcase
        end
    end

    assign code = disp_q[{digit_q, 2'b00} +: 4];

    bcd_to_7seg u_dec (
        .code_i (code),
        .seg_o  (seg_dec)
    );

    // zero_above[k]: digits k..7 are all zero (invalid codes count as non-zero).
    always_comb begin
        zero_above = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            zero_above[k] = ((disp_q >> (4 * k)) == '0);
        end
        suppress   = LZ_BLANK && (digit_q != 3'd0) && zero_above[digit_q];
        off        = blank || suppress;
        anodes_d   = off ? '1 : ~(8'b0000_0001 << digit_q);
        segments_d = off ? SEG_OFF : seg_dec;
        dp_d       = off ? 1'b1 : ~dots[digit_q];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anodes_q   <= '1;
            segments_q <= SEG_OFF;
            dp_q       <= 1'b1;
        end else begin
            anodes_q   <= anodes_d;
            segments_q <= segments_d;
            dp_q       <= dp_d;
        end
    end

    assign conv_trigger = trig_q;
    assign anodes       = anodes_q;
    assign segments     = segments_q;
    assign dp           = dp_q;

endmodule
